rx_oversampling_frontend: RTL and testbench
===========================================

# rx_oversampling_frontend

Parametrised UART receive frontend for the DWBUART datapath: synchronises the serial line, samples each bit at OVERSAMPLE ticks per bit with 3-sample majority voting, and deserialises frames of 5..MAX_DATA_BITS data bits with optional parity and 1/2 stop bits. It reports parity, framing, noise and break conditions, then emits each frame with a one-cycle valid pulse to the RX FIFO/register stage.

## Interface
- MAX_DATA_BITS, 9, widest supported data field (5..9)
- ACC_WIDTH, 16, width of the baud accumulator and cr_acc_incr_i
- OVERSAMPLE, 16, ticks per bit; even, 8..32
- SYNC_STAGES, 2, flip-flops in the uart_rx_i synchroniser (≥2)

- clk_i  in  1  system clock
- rst_i  in  1  reset; one clock domain, reset is synchronous and active-low
- cr_acc_incr_i  in  ACC_WIDTH  accumulator increment per cycle; tick = carry-out
- cr_ds_i  in  4  data bits; values <5 read as 5, >MAX_DATA_BITS read as MAX_DATA_BITS
- cr_p_i  in  2  parity: 00 none, 01 even, 10 odd, 11 none
- cr_s_i  in  1  0 = one stop bit, 1 = two stop bits
- uart_rx_i  in  1  asynchronous serial line, idle high
- frame_o  out  MAX_DATA_BITS  received data, LSB first on the line, right-aligned, unused MSBs 0
- parity_err_o  out  1  parity mismatch for the frame on frame_o
- frame_err_o  out  1  any stop bit sampled 0
- noise_err_o  out  1  any majority vote in the frame was not unanimous
- break_o  out  1  break: data, parity and first stop bit all 0
- output_valid_o  out  1  one-cycle pulse qualifying all frame outputs

## Operation
- Synchroniser flops reset to 1; rx_s = last synchroniser stage.
- acc_q <= acc_q + cr_acc_incr_i every cycle, free-running; tick = carry-out; reset 0.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK_WAIT.
- IDLE: falling edge of rx_s (previous 1, current 0) → START. Clear tick counter tc. Latch cr_ds_i, cr_p_i, cr_s_i. Config changes mid-frame have no effect.
- tc counts ticks 0..OVERSAMPLE-1, then wraps. Sample on ticks where tc = M-1, M, M+1 (M = OVERSAMPLE/2). Vote = majority of the three samples. Noise = samples not unanimous.
- START: vote 1 → false start, back to IDLE, no output. Vote 0 → DATA on the tc wrap.
- DATA: shift votes LSB-first into the data register. After latched-ds bits → PARITY if parity is enabled, else STOP1.
- PARITY: expected bit = XOR(data) for even, ~XOR(data) for odd.
- STOP1: frame_err if vote = 0. If cr_s latched: → STOP2 on wrap. Else: emit at the vote, then →IDLE (or BREAK_WAIT).
- STOP2: frame_err if vote = 0. Emit at the vote, →IDLE.
- Emit: register all outputs and pulse output_valid_o. Outputs hold until the next emit. The noise flag accumulates over start..last stop bit.
- Break: all data = 0, parity vote 0 (if enabled), STOP1 vote 0 → break_o = 1 and frame_err_o = 1. Then BREAK_WAIT, which stays until rx_s = 1, then → IDLE. No edge detect in BREAK_WAIT.
- IDLE is re-entered immediately after the last stop vote, so back-to-back frames resync on the next start edge.

## Timing
- Reset (rst_i = 0 at clk edge): state IDLE, acc_q 0, tc 0. frame_o 0, all error flags 0, break_o 0, output_valid_o 0. Synchroniser all 1.
- Reset mid-frame aborts the frame with no valid pulse.
- Pin-to-start-detect latency: SYNC_STAGES+1 cycles.
- output_valid_o is high exactly one cycle: the cycle after the clock edge on which the last stop bit's M+1 tick is processed.
- Maximum tick rate is one per cycle (incr = 2^ACC_WIDTH-1 approximates this). incr = 0 → no ticks; the FSM stalls in its state.
- Simultaneous tick and edge in IDLE: the edge wins and tc is cleared; that tick is not counted.

## Test plan
- Params default, incr 0x8000 (tick/2 cycles, 32 cycles/bit), 8N1, send 0xA5 → single valid pulse, frame_o 0x0A5, all flags 0.
- 8E1, send 0x03 with parity bit 1 → frame_o 0x003, parity_err_o 1. Next frame 0x03 with parity 0 → parity_err_o 0.
- Start glitch: line low 6 cycles, then high → no valid pulse. Following 7O2 frame 0x55 → frame_o 0x055, flags 0.
- 2-cycle low glitch centred on the M tick of data bit 3, 8N1 0xFF → frame_o 0x0FF, noise_err_o 1, frame_err_o 0.
- Break: line low for 12 bit times in 8N1 → break_o 1, frame_err_o 1, frame_o 0. No further valid while low. After return high, 0x3C is received cleanly.
- 9N2 0x1FF with second stop bit 0 → frame_err_o 1. Assert rst_i = 0 during data bit 4 of the next frame → no valid, all outputs 0.

Source files
------------

// File: rtl/rx_oversampling_frontend.sv
// UART receive frontend: synchronises the serial line, derives sample ticks from a fractional
// baud accumulator, majority-votes three mid-bit samples and deserialises one frame at a time.
module rx_oversampling_frontend #(
    parameter int unsigned MAX_DATA_BITS = 9,
    parameter int unsigned ACC_WIDTH     = 16,
    parameter int unsigned OVERSAMPLE    = 16,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [ACC_WIDTH-1:0]     cr_acc_incr_i,
    input  logic [3:0]               cr_ds_i,
    input  logic [1:0]               cr_p_i,
    input  logic                     cr_s_i,
    input  logic                     uart_rx_i,
    output logic [MAX_DATA_BITS-1:0] frame_o,
    output logic                     parity_err_o,
    output logic                     frame_err_o,
    output logic                     noise_err_o,
    output logic                     break_o,
    output logic                     output_valid_o
);

    localparam int unsigned TcWidth = $clog2(OVERSAMPLE);
    localparam int unsigned Mid     = OVERSAMPLE / 2;

    localparam logic [TcWidth-1:0] TcEarly = TcWidth'(Mid - 1);
    localparam logic [TcWidth-1:0] TcMid   = TcWidth'(Mid);
    localparam logic [TcWidth-1:0] TcLate  = TcWidth'(Mid + 1);
    localparam logic [TcWidth-1:0] TcLast  = TcWidth'(OVERSAMPLE - 1);
    localparam logic [3:0]         DsMax   = 4'(MAX_DATA_BITS);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop1,
        StStop2,
        StBreakWait
    } state_e;

    state_e state_q, state_d;

    // ------------------------------------------------------------------
    // Line synchroniser and start-edge detect
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_prev_q;
    logic                   rx_s;
    logic                   start_edge;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            sync_q    <= '1;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], uart_rx_i};
            rx_prev_q <= rx_s;
        end
    end

    assign rx_s       = sync_q[SYNC_STAGES-1];
    assign start_edge = rx_prev_q & ~rx_s;

    // ------------------------------------------------------------------
    // Fractional baud accumulator; each carry-out is one oversampling tick
    // ------------------------------------------------------------------
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 tick;

    assign {tick, acc_d} = {1'b0, acc_q} + {1'b0, cr_acc_incr_i};

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // ------------------------------------------------------------------
    // Tick counter within a bit; held at zero in IDLE so the start edge
    // always begins a fresh bit period
    // ------------------------------------------------------------------
    logic [TcWidth-1:0] tc_q, tc_d;
    logic               tc_wrap;

    assign tc_wrap = (tc_q == TcLast);

    always_comb begin
        tc_d = tc_q;
        if (state_q == StIdle) begin
            tc_d = '0;
        end else if (tick) begin
            tc_d = tc_wrap ? '0 : tc_q + TcWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            tc_q <= '0;
        end else begin
            tc_q <= tc_d;
        end
    end

    // ------------------------------------------------------------------
    // Three-sample majority vote around the bit centre
    // ------------------------------------------------------------------
    logic s_early_q, s_mid_q;
    logic vote_now, wrap_now;
    logic vote, noisy;

    assign vote_now = tick && (tc_q == TcLate);
    assign wrap_now = tick && tc_wrap;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            s_early_q <= 1'b1;
            s_mid_q   <= 1'b1;
        end else if (tick) begin
            if (tc_q == TcEarly) s_early_q <= rx_s;
            if (tc_q == TcMid)   s_mid_q   <= rx_s;
        end
    end

    assign vote  = (s_early_q & s_mid_q) | (s_early_q & rx_s) | (s_mid_q & rx_s);
    assign noisy = ~((s_early_q & s_mid_q & rx_s) | ~(s_early_q | s_mid_q | rx_s));

    // ------------------------------------------------------------------
    // Per-frame configuration and data capture
    // ------------------------------------------------------------------
    logic [3:0]               ds_q, ds_clamped;
    logic                     parity_en_q, odd_q, two_stop_q;
    logic [MAX_DATA_BITS-1:0] data_q;
    logic [3:0]               bit_cnt_q;
    logic                     par_bit_q;
    logic                     frame_err_acc_q;
    logic                     noise_acc_q;
    logic                     in_frame;
    logic                     break_now;
    logic                     par_expect;
    logic                     emit;

    always_comb begin
        ds_clamped = cr_ds_i;
        if (cr_ds_i < 4'd5) begin
            ds_clamped = 4'd5;
        end else if (cr_ds_i > DsMax) begin
            ds_clamped = DsMax;
        end
    end

    assign in_frame   = (state_q != StIdle) && (state_q != StBreakWait);
    assign break_now  = (data_q == '0) && (!parity_en_q || !par_bit_q) && !vote;
    assign par_expect = (^data_q) ^ odd_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ds_q            <= 4'd5;
            parity_en_q     <= 1'b0;
            odd_q           <= 1'b0;
            two_stop_q      <= 1'b0;
            data_q          <= '0;
            bit_cnt_q       <= '0;
            par_bit_q       <= 1'b0;
            frame_err_acc_q <= 1'b0;
            noise_acc_q     <= 1'b0;
        end else if (state_q == StIdle) begin
            if (start_edge) begin
                ds_q            <= ds_clamped;
                parity_en_q     <= cr_p_i[0] ^ cr_p_i[1];
                odd_q           <= (cr_p_i == 2'b10);
                two_stop_q      <= cr_s_i;
                data_q          <= '0;
                bit_cnt_q       <= '0;
                par_bit_q       <= 1'b0;
                frame_err_acc_q <= 1'b0;
                noise_acc_q     <= 1'b0;
            end
        end else if (vote_now && in_frame) begin
            noise_acc_q <= noise_acc_q | noisy;
            if (state_q == StData) begin
                for (int i = 0; i < int'(MAX_DATA_BITS); i++) begin
                    if (bit_cnt_q == 4'(i)) data_q[i] <= vote;
                end
                bit_cnt_q <= bit_cnt_q + 4'd1;
            end
            if (state_q == StParity) begin
                par_bit_q <= vote;
            end
            if ((state_q == StStop1 || state_q == StStop2) && !vote) begin
                frame_err_acc_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM: bit-phase transitions happen on the tick-counter wrap,
    // decisions and emission happen on the vote tick
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        emit    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_edge) state_d = StStart;
            end
            StStart: begin
                if (vote_now && vote) begin
                    state_d = StIdle;
                end else if (wrap_now) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (wrap_now && (bit_cnt_q == ds_q)) begin
                    state_d = parity_en_q ? StParity : StStop1;
                end
            end
            StParity: begin
                if (wrap_now) state_d = StStop1;
            end
            StStop1: begin
                // A break is reported on the first stop bit even with two stop bits.
                if (vote_now && break_now) begin
                    emit    = 1'b1;
                    state_d = StBreakWait;
                end else if (vote_now && !two_stop_q) begin
                    emit    = 1'b1;
                    state_d = StIdle;
                end else if (wrap_now && two_stop_q) begin
                    state_d = StStop2;
                end
            end
            StStop2: begin
                if (vote_now) begin
                    emit    = 1'b1;
                    state_d = StIdle;
                end
            end
            StBreakWait: begin
                if (rx_s) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Output registers, updated only on emit
    // ------------------------------------------------------------------
    logic [MAX_DATA_BITS-1:0] frame_q;
    logic                     parity_err_q, frame_err_q, noise_err_q, break_q, valid_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            frame_q      <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            noise_err_q  <= 1'b0;
            break_q      <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            valid_q <= emit;
            if (emit) begin
                frame_q      <= data_q;
                parity_err_q <= parity_en_q & (par_bit_q ^ par_expect);
                frame_err_q  <= frame_err_acc_q | ~vote;
                noise_err_q  <= noise_acc_q | noisy;
                break_q      <= break_now;
            end
        end
    end

    assign frame_o        = frame_q;
    assign parity_err_o   = parity_err_q;
    assign frame_err_o    = frame_err_q;
    assign noise_err_o    = noise_err_q;
    assign break_o        = break_q;
    assign output_valid_o = valid_q;

endmodule

// File: tb/tb_rx_oversampling_frontend.sv
// Bench for rx_oversampling_frontend: a directed vector table, hand-written corner sequences and
// randomized frames checked against a frame-level model of what the receiver must report.
module tb_rx_oversampling_frontend;

    localparam int MaxBits = 9;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [15:0] cr_acc_incr_i;
    logic [3:0]  cr_ds_i;
    logic [1:0]  cr_p_i;
    logic        cr_s_i;
    logic        uart_rx_i;
    logic [8:0]  frame_o;
    logic        parity_err_o, frame_err_o, noise_err_o, break_o, output_valid_o;

    always #5 clk = ~clk;

    rx_oversampling_frontend #(
        .MAX_DATA_BITS(9),
        .ACC_WIDTH    (16),
        .OVERSAMPLE   (16),
        .SYNC_STAGES  (2)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .cr_acc_incr_i (cr_acc_incr_i),
        .cr_ds_i       (cr_ds_i),
        .cr_p_i        (cr_p_i),
        .cr_s_i        (cr_s_i),
        .uart_rx_i     (uart_rx_i),
        .frame_o       (frame_o),
        .parity_err_o  (parity_err_o),
        .frame_err_o   (frame_err_o),
        .noise_err_o   (noise_err_o),
        .break_o       (break_o),
        .output_valid_o(output_valid_o)
    );

    typedef struct packed {
        logic [8:0] frame;
        logic       pe;
        logic       fe;
        logic       ne;
        logic       brk;
    } out_t;

    typedef struct {
        int         ds;
        logic [1:0] p;
        logic       s;
        logic [8:0] data;
        logic       flip;
        logic       st1;
        logic       st2;
        out_t       exp;
    } vec_t;

    int   n_checks   = 0;
    int   n_pass     = 0;
    int   bit_cycles = 32;
    int   dbl_valid  = 0;
    logic prev_valid = 1'b0;
    out_t cap_q[$];

    // Capture every emitted frame; a valid seen on two consecutive cycles is counted.
    always @(negedge clk) begin
        if (output_valid_o) begin
            if (prev_valid) dbl_valid++;
            cap_q.push_back({frame_o, parity_err_o, frame_err_o, noise_err_o, break_o});
        end
        prev_valid = output_valid_o;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic val, input int cycles);
        uart_rx_i = val;
        repeat (cycles) @(negedge clk);
    endtask

    function automatic int eff_bits(input int ds);
        if (ds < 5) return 5;
        if (ds > MaxBits) return MaxBits;
        return ds;
    endfunction

    function automatic logic [8:0] masked(input logic [8:0] data, input int n);
        logic [9:0] one = 10'd1;
        return data & 9'((one << n) - 10'd1);
    endfunction

    // Bit a transmitter places on the line so the total count of ones is even (01) or odd (10).
    function automatic logic par_bit(input logic [8:0] m, input logic [1:0] p);
        logic ones_odd = ($countones(m) % 2) == 1;
        return (p == 2'b10) ? ~ones_odd : ones_odd;
    endfunction

    function automatic out_t model(input int ds, input logic [1:0] p, input logic s,
                                   input logic [8:0] data, input logic flip,
                                   input logic st1, input logic st2);
        out_t       r;
        logic [8:0] m      = masked(data, eff_bits(ds));
        logic       par_en = (p == 2'b01) || (p == 2'b10);
        logic       sent   = par_bit(m, p) ^ flip;
        r.frame = m;
        r.pe    = par_en && flip;
        r.brk   = (m == 9'd0) && (!par_en || !sent) && !st1;
        r.fe    = !st1 || (s && !r.brk && !st2);
        r.ne    = 1'b0;
        return r;
    endfunction

    task automatic send_frame(input int ds, input logic [1:0] p, input logic s,
                              input logic [8:0] data, input logic flip, input logic st1,
                              input logic st2, input int glitch_bit, input logic scramble);
        int         n    = eff_bits(ds);
        logic [8:0] m    = masked(data, n);
        int         half = bit_cycles / 2;
        cr_ds_i = 4'(ds);
        cr_p_i  = p;
        cr_s_i  = s;
        drive(1'b0, bit_cycles);
        if (scramble) begin
            cr_ds_i = 4'($urandom_range(0, 15));
            cr_p_i  = 2'($urandom_range(0, 3));
            cr_s_i  = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < n; i++) begin
            if (i == glitch_bit) begin
                drive(m[i], half + 1);
                drive(1'b0, 2);
                drive(m[i], bit_cycles - half - 3);
            end else begin
                drive(m[i], bit_cycles);
            end
        end
        if (p == 2'b01 || p == 2'b10) drive(par_bit(m, p) ^ flip, bit_cycles);
        drive(st1, bit_cycles);
        if (s) drive(st2, bit_cycles);
        drive(1'b1, bit_cycles);
    endtask

    task automatic expect_frame(input string tag, input out_t exp);
        out_t got;
        int   waited = 0;
        while (cap_q.size() == 0 && waited < 8 * bit_cycles) begin
            @(negedge clk);
            waited++;
        end
        check({tag, ".valid_count"}, 32'(cap_q.size()), 32'd1);
        if (cap_q.size() != 0) begin
            got = cap_q.pop_front();
            check({tag, ".frame"},      32'(got.frame), 32'(exp.frame));
            check({tag, ".parity_err"}, 32'(got.pe),    32'(exp.pe));
            check({tag, ".frame_err"},  32'(got.fe),    32'(exp.fe));
            check({tag, ".noise_err"},  32'(got.ne),    32'(exp.ne));
            check({tag, ".break"},      32'(got.brk),   32'(exp.brk));
        end
        cap_q.delete();
    endtask

    task automatic expect_none(input string tag);
        check({tag, ".valid_count"}, 32'(cap_q.size()), 32'd0);
        cap_q.delete();
    endtask

    task automatic check_outputs_clear(input string tag);
        check({tag, ".frame"},      32'(frame_o),        32'd0);
        check({tag, ".parity_err"}, 32'(parity_err_o),   32'd0);
        check({tag, ".frame_err"},  32'(frame_err_o),    32'd0);
        check({tag, ".noise_err"},  32'(noise_err_o),    32'd0);
        check({tag, ".break"},      32'(break_o),        32'd0);
        check({tag, ".valid"},      32'(output_valid_o), 32'd0);
    endtask

    initial begin
        vec_t vecs[8];
        out_t exp;

        rst_i         = 1'b0;
        uart_rx_i     = 1'b1;
        cr_acc_incr_i = 16'h8000;
        cr_ds_i       = 4'd8;
        cr_p_i        = 2'b00;
        cr_s_i        = 1'b0;
        repeat (4) @(negedge clk);
        check_outputs_clear("reset");
        rst_i = 1'b1;
        drive(1'b1, 2 * bit_cycles);

        //          ds  p      s     data    flip  st1   st2   {frame, pe, fe, ne, brk}
        vecs[0] = '{8,  2'b00, 1'b0, 9'h0A5, 1'b0, 1'b1, 1'b1, {9'h0A5, 4'b0000}};
        vecs[1] = '{8,  2'b01, 1'b0, 9'h003, 1'b1, 1'b1, 1'b1, {9'h003, 4'b1000}};
        vecs[2] = '{8,  2'b01, 1'b0, 9'h003, 1'b0, 1'b1, 1'b1, {9'h003, 4'b0000}};
        vecs[3] = '{6,  2'b10, 1'b0, 9'h02A, 1'b0, 1'b1, 1'b1, {9'h02A, 4'b0000}};
        vecs[4] = '{3,  2'b00, 1'b0, 9'h1FF, 1'b0, 1'b1, 1'b1, {9'h01F, 4'b0000}};
        vecs[5] = '{15, 2'b11, 1'b0, 9'h155, 1'b0, 1'b1, 1'b1, {9'h155, 4'b0000}};
        vecs[6] = '{8,  2'b00, 1'b0, 9'h0C3, 1'b0, 1'b0, 1'b1, {9'h0C3, 4'b0100}};
        vecs[7] = '{9,  2'b00, 1'b1, 9'h1FF, 1'b0, 1'b1, 1'b0, {9'h1FF, 4'b0100}};

        foreach (vecs[i]) begin
            send_frame(vecs[i].ds, vecs[i].p, vecs[i].s, vecs[i].data, vecs[i].flip,
                       vecs[i].st1, vecs[i].st2, -1, 1'b0);
            expect_frame($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Reset during data bit 4 of a 9N2 0x1FF frame; the remaining bits are all high.
        cr_ds_i = 4'd9;
        cr_p_i  = 2'b00;
        cr_s_i  = 1'b1;
        drive(1'b0, bit_cycles);
        for (int i = 0; i < 4; i++) drive(1'b1, bit_cycles);
        drive(1'b1, 10);
        rst_i = 1'b0;
        drive(1'b1, 2);
        rst_i = 1'b1;
        check_outputs_clear("rst_mid_frame");
        drive(1'b1, 8 * bit_cycles);
        expect_none("rst_mid_frame");

        // False start, then a 7O2 frame.
        cr_ds_i = 4'd8;
        cr_p_i  = 2'b00;
        cr_s_i  = 1'b0;
        drive(1'b0, 6);
        drive(1'b1, 3 * bit_cycles);
        expect_none("false_start");
        send_frame(7, 2'b10, 1'b1, 9'h055, 1'b0, 1'b1, 1'b1, -1, 1'b0);
        expect_frame("after_false_start", {9'h055, 4'b0000});

        // Short low glitch inside data bit 3 corrupts one of the three votes.
        send_frame(8, 2'b00, 1'b0, 9'h0FF, 1'b0, 1'b1, 1'b1, 3, 1'b0);
        expect_frame("noise", {9'h0FF, 4'b0010});

        // Break: 12 bit times low, then idle, then a clean frame.
        cr_ds_i = 4'd8;
        cr_p_i  = 2'b00;
        cr_s_i  = 1'b0;
        drive(1'b0, 12 * bit_cycles);
        drive(1'b1, 2 * bit_cycles);
        expect_frame("break", {9'h000, 4'b0101});
        send_frame(8, 2'b00, 1'b0, 9'h03C, 1'b0, 1'b1, 1'b1, -1, 1'b0);
        expect_frame("after_break", {9'h03C, 4'b0000});

        // Randomized frames; configuration inputs are scrambled once the frame has started.
        for (int k = 0; k < 16; k++) begin
            int         ds   = $urandom_range(0, 15);
            logic [1:0] p    = 2'($urandom_range(0, 3));
            logic       s    = 1'($urandom_range(0, 1));
            logic [8:0] data = 9'($urandom);
            logic       flip = 1'($urandom_range(0, 1));
            logic       st1  = s ? 1'b1 : ($urandom_range(0, 3) != 0);
            logic       st2  = s ? 1'($urandom_range(0, 1)) : 1'b1;
            bit_cycles    = ($urandom_range(0, 3) == 0) ? 64 : 32;
            cr_acc_incr_i = (bit_cycles == 64) ? 16'h4000 : 16'h8000;
            drive(1'b1, bit_cycles);
            exp = model(ds, p, s, data, flip, st1, st2);
            send_frame(ds, p, s, data, flip, st1, st2, -1, 1'b1);
            expect_frame($sformatf("rand%0d", k), exp);
        end

        check("valid_one_cycle", 32'(dbl_valid), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
